// File: rtl/sequence_display.sv
// Plays back a captured sequence of 2-bit colours on one-hot LEDs with fixed on/off
// durations, then holds complete_display until en drops.
module sequence_display #(
  parameter int unsigned ON_CYCLES  = 8,
  parameter int unsigned OFF_CYCLES = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [31:0] target_sequence,
  input  logic [3:0]  sequence_len,
  output logic [3:0]  led,
  output logic [1:0]  colour_out,
  output logic        colour_valid,
  output logic        busy,
  output logic        complete_display
);

  localparam logic [CNT_W-1:0] OnLast  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OffLast = CNT_W'(OFF_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StOn, StOff, StDone} state_e;

  state_e           state_q, state_d;
  logic [31:0]      shadow_q, shadow_d;
  logic [3:0]       len_q, len_d;
  logic [3:0]       index_q, index_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] led_d;
  logic [1:0] colour_d, colour_out_d;
  logic       colour_valid_d, busy_d, complete_d;

  // State register; outputs are registered from next-state so the first lamp
  // appears in the cycle right after the capturing edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q          <= StIdle;
      shadow_q         <= '0;
      len_q            <= '0;
      index_q          <= '0;
      cnt_q            <= '0;
      led              <= '0;
      colour_out       <= '0;
      colour_valid     <= 1'b0;
      busy             <= 1'b0;
      complete_display <= 1'b0;
    end else begin
      state_q          <= state_d;
      shadow_q         <= shadow_d;
      len_q            <= len_d;
      index_q          <= index_d;
      cnt_q            <= cnt_d;
      led              <= led_d;
      colour_out       <= colour_out_d;
      colour_valid     <= colour_valid_d;
      busy             <= busy_d;
      complete_display <= complete_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    len_d    = len_q;
    index_d  = index_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en) begin
          shadow_d = target_sequence;
          len_d    = sequence_len;
          index_d  = '0;
          state_d  = (sequence_len == 4'd0) ? StDone : StOn;
        end
      end
      StOn: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == OnLast) begin
          state_d = StOff;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StOff: begin
        if (!en) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == OffLast) begin
          cnt_d   = '0;
          index_d = index_q + 4'd1;
          state_d = (index_q + 4'd1 == len_q) ? StDone : StOn;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        cnt_d = '0;
        if (!en) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic, decoded from the next state
  always_comb begin
    colour_d       = shadow_d[{index_d, 1'b0} +: 2];
    led_d          = '0;
    colour_out_d   = '0;
    colour_valid_d = 1'b0;
    busy_d         = 1'b0;
    complete_d     = 1'b0;
    unique case (state_d)
      StOn: begin
        led_d          = 4'b0001 << colour_d;
        colour_out_d   = colour_d;
        colour_valid_d = 1'b1;
        busy_d         = 1'b1;
      end
      StOff:   busy_d     = 1'b1;
      StDone:  complete_d = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sequence_display.sv
// Directed bench for sequence_display: playback timing, zero/max length, abort,
// input isolation after capture and reset mid-playback.
module tb_sequence_display;

  localparam int ON  = 8;
  localparam int OFF = 4;
  localparam int PER = ON + OFF;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [31:0] seq;
  logic [3:0]  len;
  logic [3:0]  led;
  logic [1:0]  colour_out;
  logic        colour_valid, busy, complete_display;
  logic [8:0]  obs;

  int checks = 0;
  int errors = 0;

  sequence_display #(
    .ON_CYCLES (ON),
    .OFF_CYCLES(OFF),
    .CNT_W     (16)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .target_sequence (seq),
    .sequence_len    (len),
    .led             (led),
    .colour_out      (colour_out),
    .colour_valid    (colour_valid),
    .busy            (busy),
    .complete_display(complete_display)
  );

  always #5 clk = ~clk;

  assign obs = {led, colour_out, colour_valid, busy, complete_display};

  // Expected {led, colour_out, colour_valid, busy, complete} at cycle c after the
  // capturing edge (c = 0 is the first lit cycle).
  function automatic logic [8:0] exp_out(input logic [31:0] s, input int n, input int c);
    logic [1:0] col;
    if (c >= n * PER) return 9'b0000_00_001;
    col = s[2 * (c / PER) +: 2];
    if ((c % PER) < ON) return {4'b0001 << col, col, 1'b1, 1'b1, 1'b0};
    return 9'b0000_00_010;
  endfunction

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; seq = 32'h0000_00FB; len = 4'd4;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 9'b0) begin
        errors++;
        $display("FAIL reset cyc=%0d got=%b exp=%b", i, obs, 9'b0);
      end
    end
    rst = 1'b1; en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 9'b0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, obs, 9'b0);
      end
    end
  endtask

  task automatic test_basic();
    seq = 32'h0000_00FB; len = 4'd4; en = 1'b1;
    for (int c = 0; c < 4 * PER + 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(32'h0000_00FB, 4, c)) begin
        errors++;
        $display("FAIL basic c=%0d got=%b exp=%b", c, obs, exp_out(32'h0000_00FB, 4, c));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 9'b0) begin
        errors++;
        $display("FAIL basic_release cyc=%0d got=%b exp=%b", i, obs, 9'b0);
      end
    end
  endtask

  task automatic test_zero_len();
    seq = 32'hFFFF_FFFF; len = 4'd0; en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 9'b0000_00_001) begin
        errors++;
        $display("FAIL zero_len cyc=%0d got=%b exp=%b", i, obs, 9'b0000_00_001);
      end
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL zero_len_release got=%b exp=%b", obs, 9'b0);
    end
  endtask

  task automatic test_abort_restart();
    seq = 32'h0000_00E4; len = 4'd4; en = 1'b1;
    for (int c = 0; c <= PER + 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(32'h0000_00E4, 4, c)) begin
        errors++;
        $display("FAIL abort_play c=%0d got=%b exp=%b", c, obs, exp_out(32'h0000_00E4, 4, c));
      end
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== 9'b0) begin
        errors++;
        $display("FAIL abort_idle cyc=%0d got=%b exp=%b", i, obs, 9'b0);
      end
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (led !== 4'b0001 || colour_out !== 2'd0 || colour_valid !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart got led=%b col=%0d v=%b exp led=0001 col=0 v=1",
               led, colour_out, colour_valid);
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_max_len();
    seq = 32'hC000_0000; len = 4'd15; en = 1'b1;
    for (int c = 0; c < 15 * PER + 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(32'h0000_0000, 15, c)) begin
        errors++;
        $display("FAIL max_len c=%0d got=%b exp=%b", c, obs, exp_out(32'h0000_0000, 15, c));
      end
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL max_len_release got=%b exp=%b", obs, 9'b0);
    end
  endtask

  task automatic test_input_change();
    seq = 32'h0000_00E4; len = 4'd4; en = 1'b1;
    for (int c = 0; c < 4 * PER + 2; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(32'h0000_00E4, 4, c)) begin
        errors++;
        $display("FAIL input_change c=%0d got=%b exp=%b", c, obs,
                 exp_out(32'h0000_00E4, 4, c));
      end
      if (c == 2 * PER + 2) begin
        seq = 32'hFFFF_FFFF; len = 4'd1;
      end
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_play();
    seq = 32'h0000_00E4; len = 4'd4; en = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(32'h0000_00E4, 4, c)) begin
        errors++;
        $display("FAIL rst_mid_play c=%0d got=%b exp=%b", c, obs, exp_out(32'h0000_00E4, 4, c));
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== 9'b0) begin
      errors++;
      $display("FAIL rst_mid_zero got=%b exp=%b", obs, 9'b0);
    end
    rst = 1'b1; seq = 32'h0000_00FB; len = 4'd4;
    for (int c = 0; c <= PER; c++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_out(32'h0000_00FB, 4, c)) begin
        errors++;
        $display("FAIL rst_mid_recapture c=%0d got=%b exp=%b", c, obs,
                 exp_out(32'h0000_00FB, 4, c));
      end
    end
    en = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_len();
    test_abort_restart();
    test_max_len();
    test_input_change();
    test_reset_mid_play();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
